// File: rtl/disp_imm_serializer.sv
// disp_imm_serializer
// ---------------------------------------------------------------------------
// Turns a decoded displacement and immediate back into little-endian
// instruction bytes. This is the inverse of the decoder's extraction. One
// command is accepted in IDLE. The block then emits the displacement bytes,
// followed by the immediate bytes, one byte per byte_valid/byte_ready
// handshake.
//
// Ports
//   clock                    : single clock, rising-edge state updates
//   reset                    : asynchronous, active-high reset
//   cmd_valid / cmd_ready    : command handshake (cmd_ready high only in IDLE)
//   displacement_is_present  : emit displacement bytes
//   displacement_length[3:0] : one-hot length code {full,32,16,8}
//   displacement[31:0]       : displacement value (low bytes used)
//   immediate_is_present     : emit immediate bytes
//   immediate_length[3:0]    : one-hot length code, same encoding
//   immediate[31:0]          : immediate value
//   byte_valid / byte_ready  : byte stream handshake toward the sink
//   byte_data[7:0]           : current byte
//   byte_last                : current byte is the final byte of the command
//   byte_is_immediate        : current byte belongs to the immediate field
//   done                     : one-cycle pulse after a command completes
//
// Every output is a flop. Each output is computed from the next-state
// values, so it always matches the state that the registers will hold in
// the following cycle.
// ---------------------------------------------------------------------------
module disp_imm_serializer (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        displacement_is_present,
  input  logic [3:0]  displacement_length,
  input  logic [31:0] displacement,
  input  logic        immediate_is_present,
  input  logic [3:0]  immediate_length,
  input  logic [31:0] immediate,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic [7:0]  byte_data,
  output logic        byte_last,
  output logic        byte_is_immediate,
  output logic        done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DISP = 2'd1,
    ST_IMM  = 2'd2
  } state_t;

  // Byte count for one field.
  // The lowest set bit of the length code wins.
  // An all-zero code gives an empty field, even when the field is present.
  function automatic logic [2:0] field_bytes(input logic present,
                                             input logic [3:0] len);
    logic [2:0] cnt;
    cnt = 3'd0;
    if (!present) begin
      cnt = 3'd0;
    end else if (len[0]) begin
      cnt = 3'd1;
    end else if (len[1]) begin
      cnt = 3'd2;
    end else if (len[2] || len[3]) begin
      cnt = 3'd4;
    end else begin
      cnt = 3'd0;
    end
    return cnt;
  endfunction

  // Little-endian byte select from a 32-bit value
  function automatic logic [7:0] pick_byte(input logic [31:0] value,
                                           input logic [1:0]  idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = value[7:0];
      2'd1:    b = value[15:8];
      2'd2:    b = value[23:16];
      2'd3:    b = value[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Registered state
  state_t      state_r;
  logic [31:0] disp_r;
  logic [31:0] imm_r;
  logic [2:0]  disp_cnt_r;
  logic [2:0]  imm_cnt_r;
  logic [1:0]  idx_r;
  logic        cmd_ready_r;
  logic        byte_valid_r;
  logic [7:0]  byte_data_r;
  logic        byte_last_r;
  logic        byte_is_imm_r;
  logic        done_r;

  // Next-state values
  state_t      state_s;
  logic [31:0] disp_s;
  logic [31:0] imm_s;
  logic [2:0]  disp_cnt_s;
  logic [2:0]  imm_cnt_s;
  logic [1:0]  idx_s;
  logic        done_s;
  logic        cmd_ready_s;
  logic        byte_valid_s;
  logic [7:0]  byte_data_s;
  logic        byte_last_s;
  logic        byte_is_imm_s;

  // Helpers used by the FSM
  logic [2:0]  acc_disp_cnt_s;
  logic [2:0]  acc_imm_cnt_s;
  logic        accept_s;
  logic        handshake_s;
  logic        disp_end_s;
  logic        imm_end_s;

  // Compute the command/byte handshakes, the counts to latch on accept,
  // and whether the current byte ends its field
  always_comb begin
    acc_disp_cnt_s = field_bytes(displacement_is_present, displacement_length);
    acc_imm_cnt_s  = field_bytes(immediate_is_present, immediate_length);
    accept_s       = cmd_valid && cmd_ready_r;
    handshake_s    = byte_valid_r && byte_ready;
    disp_end_s     = ({1'b0, idx_r} == (disp_cnt_r - 3'd1));
    imm_end_s      = ({1'b0, idx_r} == (imm_cnt_r - 3'd1));
  end

  // Next-state logic: field sequencing, byte index, and the done request
  always_comb begin
    state_s    = state_r;
    disp_s     = disp_r;
    imm_s      = imm_r;
    disp_cnt_s = disp_cnt_r;
    imm_cnt_s  = imm_cnt_r;
    idx_s      = idx_r;
    done_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          disp_s     = displacement;
          imm_s      = immediate;
          disp_cnt_s = acc_disp_cnt_s;
          imm_cnt_s  = acc_imm_cnt_s;
          idx_s      = 2'd0;
          if (acc_disp_cnt_s != 3'd0) begin
            state_s = ST_DISP;
          end else if (acc_imm_cnt_s != 3'd0) begin
            state_s = ST_IMM;
          end else begin
            // Zero-byte command: it completes right away.
            state_s = ST_IDLE;
            done_s  = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DISP: begin
        if (handshake_s) begin
          if (disp_end_s) begin
            idx_s = 2'd0;
            if (imm_cnt_r != 3'd0) begin
              state_s = ST_IMM;
            end else begin
              state_s = ST_IDLE;
              done_s  = 1'b1;
            end
          end else begin
            idx_s = idx_r + 2'd1;
          end
        end else begin
          state_s = ST_DISP;
        end
      end
      ST_IMM: begin
        if (handshake_s) begin
          if (imm_end_s) begin
            idx_s   = 2'd0;
            state_s = ST_IDLE;
            done_s  = 1'b1;
          end else begin
            idx_s = idx_r + 2'd1;
          end
        end else begin
          state_s = ST_IMM;
        end
      end
      default: begin
        // An unreachable encoding falls back to a clean idle.
        state_s = ST_IDLE;
        idx_s   = 2'd0;
      end
    endcase
  end

  // Output values for the next cycle, derived from the next state.
  // A stalled byte therefore reproduces itself, and it stays stable.
  always_comb begin
    cmd_ready_s   = 1'b0;
    byte_valid_s  = 1'b0;
    byte_data_s   = 8'h00;
    byte_last_s   = 1'b0;
    byte_is_imm_s = 1'b0;
    case (state_s)
      ST_IDLE: begin
        cmd_ready_s = 1'b1;
      end
      ST_DISP: begin
        byte_valid_s  = 1'b1;
        byte_data_s   = pick_byte(disp_s, idx_s);
        byte_last_s   = ({1'b0, idx_s} == (disp_cnt_s - 3'd1)) &&
                        (imm_cnt_s == 3'd0);
        byte_is_imm_s = 1'b0;
      end
      ST_IMM: begin
        byte_valid_s  = 1'b1;
        byte_data_s   = pick_byte(imm_s, idx_s);
        byte_last_s   = ({1'b0, idx_s} == (imm_cnt_s - 3'd1));
        byte_is_imm_s = 1'b1;
      end
      default: begin
        cmd_ready_s = 1'b0;
      end
    endcase
  end

  // State, latch and output registers.
  // Reset abandons any command in flight at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      disp_r        <= 32'h0000_0000;
      imm_r         <= 32'h0000_0000;
      disp_cnt_r    <= 3'd0;
      imm_cnt_r     <= 3'd0;
      idx_r         <= 2'd0;
      cmd_ready_r   <= 1'b1;
      byte_valid_r  <= 1'b0;
      byte_data_r   <= 8'h00;
      byte_last_r   <= 1'b0;
      byte_is_imm_r <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      state_r       <= state_s;
      disp_r        <= disp_s;
      imm_r         <= imm_s;
      disp_cnt_r    <= disp_cnt_s;
      imm_cnt_r     <= imm_cnt_s;
      idx_r         <= idx_s;
      cmd_ready_r   <= cmd_ready_s;
      byte_valid_r  <= byte_valid_s;
      byte_data_r   <= byte_data_s;
      byte_last_r   <= byte_last_s;
      byte_is_imm_r <= byte_is_imm_s;
      done_r        <= done_s;
    end
  end

  assign cmd_ready         = cmd_ready_r;
  assign byte_valid        = byte_valid_r;
  assign byte_data         = byte_data_r;
  assign byte_last         = byte_last_r;
  assign byte_is_immediate = byte_is_imm_r;
  assign done              = done_r;

endmodule

// File: doc/disp_imm_serializer.md
# disp_imm_serializer

Serializes a decoded displacement and immediate back into little-endian instruction bytes, one byte per handshake. It performs the inverse of the decoder's displacement/immediate extraction. It sits on the encode/replay side of the instruction path: a command carries the same presence flags, one-hot length codes and 32-bit values the decoder produces, and the block emits the byte stream (displacement bytes first, then immediate bytes) toward an instruction byte sink.

## Interface
- Parameters: none.
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command; high only in IDLE.
- displacement_is_present  input  1  emit displacement bytes.
- displacement_length  input  4  one-hot length code: [0]=8-bit, [1]=16-bit, [2]=32-bit, [3]=full (32-bit).
- displacement  input  32  displacement value; the low bytes are used.
- immediate_is_present  input  1  emit immediate bytes.
- immediate_length  input  4  one-hot length code, same encoding as displacement_length.
- immediate  input  32  immediate value.
- byte_valid  output  1  byte_data is valid.
- byte_ready  input  1  sink accepts the byte.
- byte_data  output  8  current byte.
- byte_last  output  1  current byte is the final byte of the command.
- byte_is_immediate  output  1  current byte belongs to the immediate (0 means displacement).
- done  output  1  one-cycle pulse when a command completes.

## Operation
- Command accept: cmd_valid & cmd_ready at a clock edge. At that edge the block latches both values and computes the byte counts.
- Byte count per field:
  - If the field's present flag is 0, the count is 0.
  - Otherwise the count comes from the length code: bit0 gives 1, bit1 gives 2, bit2 gives 4, bit3 gives 4.
  - The lowest set bit wins when more than one bit is set.
  - An all-zero length code with present=1 gives 0 bytes.
- Byte order: displacement bytes [7:0], [15:8], ... then immediate bytes [7:0], [15:8], ... (little-endian, displacement first).
- State machine:
  - IDLE: cmd_ready=1. On accept:
    - go to DISP if the displacement count is nonzero;
    - else go to IMM if the immediate count is nonzero;
    - else stay in IDLE and pulse done next cycle.
  - DISP: byte_valid=1, byte_is_immediate=0. On each byte handshake the byte index increments. After the last displacement byte is accepted, go to IMM if the immediate count is nonzero, else go to IDLE.
  - IMM: byte_valid=1, byte_is_immediate=1. After the last immediate byte is accepted, go to IDLE.
- byte_last=1 on the final byte of the command: the last IMM byte, or the last DISP byte when the immediate count is 0.
- done: registered. It is high for exactly the one cycle after the final byte handshake, or the one cycle after accepting a zero-byte command.
- Input values are ignored outside the accept edge. The latched copies drive all output bytes.

## Timing
- Reset values:
  - state: IDLE
  - cmd_ready: 1
  - byte_valid: 0
  - byte_data: 0x00
  - byte_last: 0
  - byte_is_immediate: 0
  - done: 0
  - internal counters and latches: 0
- Latency: command accepted at edge N gives the first byte valid in the cycle after edge N. With byte_ready held at 1, the block sends one byte per cycle with no bubble between DISP and IMM.
- Last byte accepted at edge M: IDLE and cmd_ready=1 in cycle M+1, and done=1 in cycle M+1. A new command can be accepted at edge M+1. The output becomes valid again at M+2.
- Backpressure: while byte_valid=1 and byte_ready=0, byte_data, byte_last and byte_is_immediate hold stable. byte_valid never drops before the handshake.
- Maximum command duration: 8 bytes (4 displacement + 4 immediate).
- Reset asserted mid-command: the command is abandoned immediately (asynchronously) and all outputs take their reset values. No done pulse is generated for it.
- cmd_valid during DISP/IMM: ignored; cmd_ready=0.

## Test plan
- Command: disp present, len=0001, value 0x00000012; imm present, len=0100, value 0xAABBCCDD; byte_ready=1 throughout.
  Expected: bytes 12, DD, CC, BB, AA on consecutive cycles; byte_is_immediate is 0,1,1,1,1; byte_last only on AA; done one cycle later.
- Command: disp present, len=1000, value 0x11223344; imm absent.
  Expected: bytes 44, 33, 22, 11; byte_last on 11.
  Then toggle byte_ready 1,0,0,1,0,1,1: each byte holds stable while stalled, and the order is unchanged.
- Command: both fields absent (or present with length 0000).
  Expected: cmd_ready stays 1, no byte_valid, done pulses exactly one cycle after accept.
- Command: imm present, len=0011, value 0x0000BEEF; disp absent.
  Expected: lowest set bit wins, so a single byte EF is sent with byte_last=1.
  Then: disp len=0010, value 0x5678, imm len=0010, value 0x9ABC. Expected: 78, 56, BC, 9A.
- Reset asserted after the second byte of an 8-byte command.
  Expected: outputs reach reset values without waiting for a clock edge; no done pulse. After release, a fresh 1-byte command (disp 0x7F) produces a single byte 7F with byte_last=1.
- Back-to-back commands with cmd_valid held high.
  Expected: the second command is accepted exactly at the edge after the first's last-byte handshake. cmd_valid is ignored while the block is busy.
